player_stats_bcd: RTL and testbench

//  Synchronous, parametrised successor of the two-digit/one-life stat keeper.

---
 rtl/player_stats_bcd.sv | 149 ++++++++++++++
 tb/tb_player_stats_bcd.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_stats_bcd.sv
// player_stats_bcd: NDIGITS-wide BCD score with digit-serial ripple add, lives counter and game-over.
// Optional extra-life award on a carry into digit EXTRA_DIGIT: define PLAYER_STATS_EXTRA_LIFE_EN.
module player_stats_bcd #(
   parameter int NDIGITS     = 4,
   parameter int INIT_LIVES  = 3,
   parameter int MAX_LIVES   = 9,
   parameter int SAT_ON_OVF  = 1,
   parameter int EXTRA_DIGIT = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   add_en,
   input  logic [3:0]             add_val,
   input  logic                   dec_life,
   output logic [4*NDIGITS-1:0]   score,
   output logic [3:0]             lives,
   output logic                   busy,
   output logic                   game_over,
   output logic                   add_drop,
   output logic                   score_ovf
);

   localparam int IDX_W = $clog2(NDIGITS);

   if (NDIGITS < 2 || NDIGITS > 8 || INIT_LIVES < 1 || INIT_LIVES > MAX_LIVES ||
       MAX_LIVES > 15 || EXTRA_DIGIT < 0 || EXTRA_DIGIT >= NDIGITS) begin : g_bad_cfg
      $error("player_stats_bcd: illegal parameter set");
   end

   typedef enum logic {IDLE, ADD} state_t;

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic [3:0]       opnd;
   logic             pend_v;
   logic [3:0]       pend_val;

   logic [3:0] cur_dig;
   logic [4:0] dsum;
   logic [4:0] dsum_m10;
   logic [3:0] wr_dig;
   logic       carry;
   logic       last;
   logic       done;
   logic       ovf_now;
   logic       free;
   logic       pend_go;
   logic       new_go;
   logic       store;
   logic       drop;
   logic       lives_dec;
   logic       award;
   logic [3:0] lives_nxt;

   function automatic logic [3:0] clamp_bcd(input logic [3:0] v);
      return (v > 4'd9) ? 4'd9 : v;
   endfunction

   always_comb begin
      cur_dig = 4'd0;
      for (int k = 0; k < NDIGITS; k++)
         if (int'(idx) == k) cur_dig = score[4*k +: 4];
   end

   assign dsum     = {1'b0, cur_dig} + {1'b0, opnd};
   assign dsum_m10 = dsum - 5'd10;
   assign carry    = (dsum > 5'd9);
   assign wr_dig   = carry ? dsum_m10[3:0] : dsum[3:0];
   assign last     = (int'(idx) == NDIGITS - 1);
   assign done     = (state == ADD) && (!carry || last);
   assign ovf_now  = (state == ADD) && carry && last;
   assign busy     = (state == ADD);

   // A waiting pending request always goes first; any request arriving while the slot is
   // occupied (or after game over) is discarded, even if the adder happens to be idle.
   assign free    = (state == IDLE) || done;
   assign pend_go = free && pend_v;
   assign new_go  = add_en && !game_over && !pend_v && (state == IDLE);
   assign store   = add_en && !game_over && !pend_v && (state == ADD);
   assign drop    = add_en && (game_over || pend_v);

`ifdef PLAYER_STATS_EXTRA_LIFE_EN
   assign award = (state == ADD) && (EXTRA_DIGIT != 0) && (int'(idx) == EXTRA_DIGIT) &&
                  !(ovf_now && (SAT_ON_OVF != 0)) && (lives != 4'(MAX_LIVES)) && !game_over;
`else
   assign award = 1'b0;
`endif

   assign lives_dec = dec_life && (lives != 4'd0);

   always_comb begin
      lives_nxt = lives;
      if (lives_dec && !award)      lives_nxt = lives - 4'd1;
      else if (award && !lives_dec) lives_nxt = lives + 4'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         idx       <= '0;
         opnd      <= 4'd0;
         pend_v    <= 1'b0;
         pend_val  <= 4'd0;
         score     <= '0;
         lives     <= 4'(INIT_LIVES);
         game_over <= 1'b0;
         add_drop  <= 1'b0;
         score_ovf <= 1'b0;
      end else begin
         add_drop  <= drop;
         lives     <= lives_nxt;
         game_over <= (lives_nxt == 4'd0);
         if (ovf_now) score_ovf <= 1'b1;

         if (state == ADD) begin
            if (ovf_now && (SAT_ON_OVF != 0)) begin
               score <= {NDIGITS{4'h9}};
            end else begin
               for (int k = 0; k < NDIGITS; k++)
                  if (int'(idx) == k) score[4*k +: 4] <= wr_dig;
            end
            if (!done) begin
               idx  <= idx + 1'b1;
               opnd <= 4'd1;
            end
         end

         if (pend_go) begin
            state <= ADD;
            idx   <= '0;
            opnd  <= pend_val;
         end else if (new_go) begin
            state <= ADD;
            idx   <= '0;
            opnd  <= clamp_bcd(add_val);
         end else if (done) begin
            state <= IDLE;
         end

         if (store) begin
            pend_v   <= 1'b1;
            pend_val <= clamp_bcd(add_val);
         end else if (pend_go) begin
            pend_v <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_player_stats_bcd.sv
// Bench for player_stats_bcd: integer-level reference model checked every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_player_stats_bcd;

   localparam int ND     = 4;
   localparam int INIT_L = 3;
   localparam int MAX_L  = 9;
   localparam int XD     = 3;
   localparam int MODV   = 10000;

   logic        clk = 1'b0;
   logic        reset;
   logic        add_en;
   logic [3:0]  add_val;
   logic        dec_life;
   logic [15:0] score, score_w;
   logic [3:0]  lives, lives_w;
   logic        busy, busy_w, game_over, go_w, add_drop, drop_w, score_ovf, ovf_w;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   player_stats_bcd #(.NDIGITS(ND), .INIT_LIVES(INIT_L), .MAX_LIVES(MAX_L),
                      .SAT_ON_OVF(1), .EXTRA_DIGIT(XD)) dut (
      .clk(clk), .reset(reset), .add_en(add_en), .add_val(add_val), .dec_life(dec_life),
      .score(score), .lives(lives), .busy(busy), .game_over(game_over),
      .add_drop(add_drop), .score_ovf(score_ovf));

   player_stats_bcd #(.NDIGITS(ND), .INIT_LIVES(INIT_L), .MAX_LIVES(MAX_L),
                      .SAT_ON_OVF(0), .EXTRA_DIGIT(XD)) dut_w (
      .clk(clk), .reset(reset), .add_en(add_en), .add_val(add_val), .dec_life(dec_life),
      .score(score_w), .lives(lives_w), .busy(busy_w), .game_over(go_w),
      .add_drop(drop_w), .score_ovf(ovf_w));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic int pow10(input int k);
      int r = 1;
      for (int i = 0; i < k; i++) r *= 10;
      return r;
   endfunction

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] b;
      int x = v;
      for (int k = 0; k < ND; k++) begin
         b[4*k +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return b;
   endfunction

   // Reference model: score as an integer; an in-flight add is (base, operand, cycles elapsed, length).
   int  m_score, m_lives, m_base, m_opnd, m_done, m_len;
   bit  m_go, m_ovf, m_drop, m_act;
   int  pq[$];
   bit  chk_en = 1'b0;

   task automatic m_launch(input int v);
      m_act  = 1'b1;
      m_base = m_score;
      m_opnd = v;
      m_done = 0;
      m_len  = 1;
      for (int j = 0; j < ND - 1; j++)
         if ((m_base % pow10(j + 1)) + v >= pow10(j + 1)) m_len = j + 2;
   endtask

   always @(posedge clk) begin
      bit was_idle, pv, go, award, fin, launch_new, store, dec;
      int v, v2, sum;
      if (reset) begin
         m_score = 0; m_lives = INIT_L; m_go = 0; m_ovf = 0; m_drop = 0; m_act = 0;
         pq.delete();
      end else begin
         was_idle = !m_act;
         pv       = (pq.size() != 0);
         go       = m_go;
         award    = 0;
         fin      = 0;
         sum      = 0;
         v        = (add_val > 4'd9) ? 9 : int'(add_val);
         m_drop     = add_en && (go || pv);
         launch_new = add_en && !go && !pv && was_idle;
         store      = add_en && !go && !pv && !was_idle;
         if (m_act) begin
            m_done++;
            sum = m_base + m_opnd;
            if (m_done < m_len) begin
               m_score = (sum % pow10(m_done)) + (m_base - (m_base % pow10(m_done)));
            end else begin
               fin   = 1;
               m_act = 0;
               if (sum >= MODV) begin
                  m_ovf   = 1;
                  m_score = MODV - 1;
               end else begin
                  m_score = sum;
               end
            end
`ifdef PLAYER_STATS_EXTRA_LIFE_EN
            if ((m_done - 1) == XD && XD > 0 && !(fin && sum >= MODV) && m_lives < MAX_L && !go)
               award = 1;
`endif
         end
         if (was_idle || fin) begin
            if (pv) begin
               v2 = pq.pop_front();
               m_launch(v2);
            end else if (launch_new) begin
               m_launch(v);
            end
         end
         if (store) pq.push_back(v);
         dec     = dec_life && (m_lives != 0);
         m_lives = m_lives - int'(dec) + int'(award);
         m_go    = (m_lives == 0);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("score",     32'(score),     32'(to_bcd(m_score)));
         chk("lives",     32'(lives),     32'(m_lives));
         chk("busy",      32'(busy),      32'(m_act));
         chk("game_over", 32'(game_over), 32'(m_go));
         chk("add_drop",  32'(add_drop),  32'(m_drop));
         chk("score_ovf", 32'(score_ovf), 32'(m_ovf));
      end
   end

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic pulse_add(input int v);
      add_en  = 1'b1;
      add_val = 4'(v);
      @(negedge clk);
      add_en  = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("idle_timeout", 32'(busy), 32'd0);
   endtask

   task automatic add_wait(input int v);
      pulse_add(v);
      wait_idle();
   endtask

   initial begin
      int nb, drops;
      reset = 1'b1; add_en = 1'b0; add_val = 4'd0; dec_life = 1'b0;
      @(negedge clk);
      chk_en = 1'b1;
      do_reset();

      // reset values, then a single add of 7
      chk("rst_score", 32'(score), 32'h0);
      chk("rst_lives", 32'(lives), 32'd3);
      chk("rst_busy",  32'(busy),  32'd0);
      chk("rst_ovf",   32'(score_ovf), 32'd0);
      pulse_add(7);
      chk("t1_busy",  32'(busy),  32'd1);
      chk("t1_score0", 32'(score), 32'h0);
      @(negedge clk);
      chk("t1_score", 32'(score), 32'h0007);
      chk("t1_idle",  32'(busy),  32'd0);

      // 0095 + 7 ripples through three digits
      do_reset();
      for (int i = 0; i < 10; i++) add_wait(9);
      add_wait(5);
      chk("t2_base", 32'(score), 32'h0095);
      pulse_add(7);
      nb = 0;
      while (busy && nb < 10) begin
         nb++;
         if (nb == 2) chk("t2_mid", 32'(score), 32'h0092);
         @(negedge clk);
      end
      chk("t2_busy_cycles", 32'(nb), 32'd3);
      chk("t2_score", 32'(score), 32'h0102);

      // overflow: saturating and wrapping variants
      do_reset();
      for (int i = 0; i < 1110; i++) add_wait(9);
      add_wait(8);
      chk("t3_base",   32'(score),   32'h9998);
      chk("t3_base_w", 32'(score_w), 32'h9998);
      add_wait(5);
      chk("t3_sat",   32'(score),     32'h9999);
      chk("t3_ovf",   32'(score_ovf), 32'd1);
      chk("t3_wrap",  32'(score_w),   32'h0003);
      chk("t3_ovf_w", 32'(ovf_w),     32'd1);

      // three back-to-back requests: two summed, third dropped
      do_reset();
      add_en = 1'b1; add_val = 4'd1; @(negedge clk);
      add_val = 4'd2; @(negedge clk);
      add_val = 4'd3; @(negedge clk);
      add_en = 1'b0;
      drops = 0;
      for (int i = 0; i < 6; i++) begin
         if (add_drop) drops++;
         @(negedge clk);
      end
      wait_idle();
      chk("t4_drops", 32'(drops), 32'd1);
      chk("t4_score", 32'(score), 32'h0003);

      // lives run out, later adds are refused
      do_reset();
      for (int i = 0; i < 4; i++) begin
         dec_life = 1'b1;
         @(negedge clk);
         dec_life = 1'b0;
         chk("t5_lives", 32'(lives), (i < 3) ? 32'(2 - i) : 32'd0);
         chk("t5_go",    32'(game_over), (i >= 2) ? 32'd1 : 32'd0);
      end
      pulse_add(4);
      chk("t5_drop", 32'(add_drop), 32'd1);
      chk("t5_busy", 32'(busy),     32'd0);

      // reset in the middle of a rippling add
      do_reset();
      for (int i = 0; i < 111; i++) add_wait(9);
      dec_life = 1'b1; @(negedge clk); dec_life = 1'b0;
      chk("t5_base", 32'(score), 32'h0999);
      pulse_add(1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("t5_rst_score", 32'(score), 32'h0);
      chk("t5_rst_lives", 32'(lives), 32'd3);
      chk("t5_rst_busy",  32'(busy),  32'd0);
      chk("t5_rst_go",    32'(game_over), 32'd0);
      chk("t5_rst_drop",  32'(add_drop),  32'd0);

`ifdef PLAYER_STATS_EXTRA_LIFE_EN
      do_reset();
      for (int i = 0; i < 111; i++) add_wait(9);
      dec_life = 1'b1; @(negedge clk); dec_life = 1'b0;
      add_wait(1);
      chk("t6_score", 32'(score), 32'h1000);
      chk("t6_lives", 32'(lives), 32'd3);
`endif

      // randomized traffic
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         reset    = ($urandom_range(0, 399) == 0);
         add_en   = ($urandom_range(0, 2) == 0);
         add_val  = 4'($urandom_range(0, 15));
         dec_life = ($urandom_range(0, 119) == 0);
         @(negedge clk);
      end
      reset = 1'b0; add_en = 1'b0; dec_life = 1'b0;
      repeat (10) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
